// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter: round-robin access from NREQ masters to a shared SR flop bank.
// Define SR_ARB_VERIFY_EN to add q_in readback with up to MAX_RETRY re-drives.
module sr_bank_arbiter #(
    parameter int NREQ      = 4,
    parameter int NBITS     = 8,
    parameter int IDXW      = 3,
    parameter int MAX_RETRY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IDXW-1:0] idx,
    input  logic [NBITS-1:0]     q_in,
    output logic [NBITS-1:0]     s_out,
    output logic [NBITS-1:0]     r_out,
    output logic [NREQ-1:0]      gnt,
    output logic                 err,
    output logic                 busy
);

    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef SR_ARB_VERIFY_EN
    localparam int RTW = $clog2(MAX_RETRY + 2);
    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;
`endif

    state_t state_q, state_d;

    logic [RRW-1:0]   rr_q, rr_d;
    logic [RRW-1:0]   win_q, win_d;
    logic             op_q, op_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             err_q, err_d;
    logic [NBITS-1:0] s_d, r_d;

    logic             found;
    logic [RRW-1:0]   pick;
    logic             pick_op;
    logic [IDXW-1:0]  pick_idx;
    logic             drive_ok;

`ifdef SR_ARB_VERIFY_EN
    logic [RTW-1:0]   rty_q, rty_d;
    logic             q_bit;
`else
    // Readback and retry budget only matter in the verify build.
    logic             unused_cfg;
    assign unused_cfg = ^q_in ^ (MAX_RETRY < 0);
`endif

    function automatic logic in_rng(logic [IDXW-1:0] i);
        return int'(i) < NBITS;
    endfunction

    function automatic logic [NBITS-1:0] bit_sel(logic [IDXW-1:0] i);
        logic [NBITS-1:0] v;
        v = '0;
        for (int b = 0; b < NBITS; b++) begin
            if (int'(i) == b) begin
                v[b] = 1'b1;
            end
        end
        return v;
    endfunction

    // Round-robin search: first requester at or above rr, wrapping.
    always_comb begin : arb
        int j;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rr_q) + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = RRW'(j);
            end
        end
    end

    // Operation and target bit of the current search winner.
    always_comb begin
        pick_op  = op[pick];
        pick_idx = idx[int'(pick)*IDXW +: IDXW];
    end

`ifdef SR_ARB_VERIFY_EN
    // Readback of the latched target bit.
    always_comb begin
        q_bit = 1'b0;
        for (int b = 0; b < NBITS; b++) begin
            if (int'(idx_q) == b) begin
                q_bit = q_in[b];
            end
        end
    end
`endif

    // Next-state logic for the command sequencer.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        op_d    = op_q;
        idx_d   = idx_q;
        err_d   = err_q;
`ifdef SR_ARB_VERIFY_EN
        rty_d   = rty_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    op_d    = pick_op;
                    idx_d   = pick_idx;
                    err_d   = 1'b0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (!in_rng(idx_q)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
`ifdef SR_ARB_VERIFY_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef SR_ARB_VERIFY_EN
            CHECK: begin
                if (q_bit == op_q) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (int'(rty_q) < MAX_RETRY) begin
                    rty_d   = rty_q + 1'b1;
                    state_d = DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (int'(win_q) == NREQ - 1) begin
                    rr_d = '0;
                end else begin
                    rr_d = win_q + 1'b1;
                end
`ifdef SR_ARB_VERIFY_EN
                rty_d = '0;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The pulse is registered: one bit, one cycle, only S or only R.
    always_comb begin
        drive_ok = (state_d == DRIVE) && in_rng(idx_d);
        s_d      = '0;
        r_d      = '0;
        if (drive_ok) begin
            if (op_d) begin
                s_d = bit_sel(idx_d);
            end else begin
                r_d = bit_sel(idx_d);
            end
        end
    end

    // State, pointer, latched command and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            op_q    <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            s_out   <= '0;
            r_out   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            s_out   <= s_d;
            r_out   <= r_d;
        end
    end

`ifdef SR_ARB_VERIFY_EN
    // Retry counter, cleared on every completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rty_q <= '0;
        end else begin
            rty_q <= rty_d;
        end
    end
`endif

    // Completion outputs decode directly from the DONE state.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = (state_q == DONE) && (int'(win_q) == i);
        end
        err  = (state_q == DONE) && err_q;
        busy = (state_q != IDLE);
    end

endmodule
